// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter / rotator with a valid/ready
// handshake, zero and carry flags, and a sideband tag carried per beat.
// REG_MID=1 splits the barrel levels across two register stages; REG_MID=0
// runs every level in front of a single output register.
module shifter_pipe #(
    parameter int WIDTH   = 16,
    parameter int REG_MID = 1,
    parameter int TAGW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         src,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [2:0]               op,
    input  logic [TAGW-1:0]          tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     zr,
    output logic                     cy,
    output logic [TAGW-1:0]          tag_out
);

    localparam int SHW       = $clog2(WIDTH);
    localparam int LO_LEVELS = SHW / 2;

    // Opcodes 110 and 111 are not listed; they fall into the pass default.
    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             cy;
    } shres_t;

    // Applies each barrel level whose amount bit is set. The carry tracks the
    // bit leaving the word at the highest active level, which is the overall
    // last bit shifted or rotated out, so levels can be split across stages
    // by carrying the partial value and carry candidate forward.
    function automatic shres_t shift_levels(input logic [WIDTH-1:0] val_in,
                                            input logic             cy_in,
                                            input op_e              op_i,
                                            input logic [SHW-1:0]   amt);
        shres_t           r;
        logic [SHW-1:0]   a;
        logic [WIDTH-1:0] t;
        int               s;
        r.val = val_in;
        r.cy  = cy_in;
        a     = amt;
        for (int k = 0; k < SHW; k++) begin
            s = 1 << k;
            if (a[0]) begin
                case (op_i)
                    OP_SLL: begin
                        t     = r.val >> (WIDTH - s);
                        r.cy  = t[0];
                        r.val = r.val << s;
                    end
                    OP_SRL: begin
                        t     = r.val >> (s - 1);
                        r.cy  = t[0];
                        r.val = r.val >> s;
                    end
                    OP_SRA: begin
                        t     = r.val >> (s - 1);
                        r.cy  = t[0];
                        r.val = WIDTH'($signed(r.val) >>> s);
                    end
                    OP_ROL: begin
                        t     = r.val >> (WIDTH - s);
                        r.cy  = t[0];
                        r.val = (r.val << s) | (r.val >> (WIDTH - s));
                    end
                    OP_ROR: begin
                        t     = r.val >> (s - 1);
                        r.cy  = t[0];
                        r.val = (r.val >> s) | (r.val << (WIDTH - s));
                    end
                    default: begin
                    end
                endcase
            end
            a = a >> 1;
        end
        return r;
    endfunction

    // Beat presented to the output stage, from stage A or straight from the ports.
    logic             feed_valid;
    logic [WIDTH-1:0] feed_val;
    logic             feed_cy;
    op_e              feed_op;
    logic [SHW-1:0]   feed_amt;
    logic [TAGW-1:0]  feed_tag;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             cy_q, cy_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic             b_adv;
    shres_t           b_res;

    assign b_adv = ~out_valid_q | out_ready;

    if (REG_MID != 0) begin : g_mid
        localparam int             HI_BITS = SHW - LO_LEVELS;
        localparam logic [SHW-1:0] LO_MASK = SHW'((1 << LO_LEVELS) - 1);

        logic               a_valid_q, a_valid_d;
        logic [WIDTH-1:0]   a_val_q, a_val_d;
        logic               a_cy_q, a_cy_d;
        op_e                a_op_q, a_op_d;
        logic [HI_BITS-1:0] a_amt_q, a_amt_d;
        logic [TAGW-1:0]    a_tag_q, a_tag_d;
        logic               a_adv;
        shres_t             a_res;

        // A full stage A can still take a beat when stage B drains it this cycle.
        assign a_adv    = ~a_valid_q | b_adv;
        assign in_ready = a_adv;

        // Stage A next state: lower barrel levels on the incoming beat.
        always_comb begin
            // NOTE: every comb output gets a hold value first so no path infers a latch.
            a_valid_d = a_valid_q;
            a_val_d   = a_val_q;
            a_cy_d    = a_cy_q;
            a_op_d    = a_op_q;
            a_amt_d   = a_amt_q;
            a_tag_d   = a_tag_q;
            a_res     = shift_levels(src, 1'b0, op_e'(op), shamt & LO_MASK);
            if (a_adv) begin
                a_valid_d = in_valid;
                if (in_valid) begin
                    a_val_d = a_res.val;
                    a_cy_d  = a_res.cy;
                    a_op_d  = op_e'(op);
                    a_amt_d = shamt[SHW-1:LO_LEVELS];
                    a_tag_d = tag_in;
                end
            end
        end

        // Stage A register; reset discards any beat in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_valid_q <= 1'b0;
                a_val_q   <= '0;
                a_cy_q    <= 1'b0;
                a_op_q    <= OP_PASS;
                a_amt_q   <= '0;
                a_tag_q   <= '0;
            end else begin
                // NOTE: non-blocking so every flop samples pre-edge values.
                a_valid_q <= a_valid_d;
                a_val_q   <= a_val_d;
                a_cy_q    <= a_cy_d;
                a_op_q    <= a_op_d;
                a_amt_q   <= a_amt_d;
                a_tag_q   <= a_tag_d;
            end
        end

        assign feed_valid = a_valid_q;
        assign feed_val   = a_val_q;
        assign feed_cy    = a_cy_q;
        assign feed_op    = a_op_q;
        assign feed_amt   = {a_amt_q, {LO_LEVELS{1'b0}}};
        assign feed_tag   = a_tag_q;
    end else begin : g_direct
        assign in_ready   = b_adv;
        assign feed_valid = in_valid;
        assign feed_val   = src;
        assign feed_cy    = 1'b0;
        assign feed_op    = op_e'(op);
        assign feed_amt   = shamt;
        assign feed_tag   = tag_in;
    end

    // Stage B next state: remaining levels, flags, and hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        zr_d        = zr_q;
        cy_d        = cy_q;
        tag_d       = tag_q;
        b_res       = shift_levels(feed_val, feed_cy, feed_op, feed_amt);
        if (b_adv) begin
            out_valid_d = feed_valid;
            if (feed_valid) begin
                out_d = b_res.val;
                zr_d  = ~|b_res.val;
                cy_d  = b_res.cy;
                tag_d = feed_tag;
            end
        end
    end

    // Stage B (output) register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zr_q        <= 1'b0;
            cy_q        <= 1'b0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zr_q        <= zr_d;
            cy_q        <= cy_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign cy        = cy_q;
    assign tag_out   = tag_q;

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational shifter used by the ALU. It takes one shift operation per cycle over a valid/ready handshake and produces a registered result with zero and carry flags after 1 or 2 cycles. It adds two rotate modes and a carry-out flag. Each output beat carries a caller tag, so the block can sit between the execute issue logic and writeback with backpressure.

Parameters:
WIDTH, 16, data width; power of two, minimum 4.
SHW, log2(WIDTH), shift-amount width; derived, never overridden.
REG_MID, 1, 1 inserts a register after the lower half of the shift levels (latency 2); 0 gives a single output register (latency 1).
TAGW, 4, width of the sideband tag carried with each operation.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat this cycle.
src  in  WIDTH  operand.
shamt  in  SHW  shift amount, 0..WIDTH-1.
op  in  3  000 pass, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 pass.
tag_in  in  TAGW  sideband tag; returned unchanged with the result.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the result.
out  out  WIDTH  shifted or rotated result.
zr  out  1  1 when out == 0.
cy  out  1  last bit shifted or rotated out.
tag_out  out  TAGW  tag of this result.

Behaviour:
- Beat transfer: an input beat is accepted when in_valid & in_ready; a result is delivered when out_valid & out_ready.
- Shift structure: log2 barrel levels. Level k shifts by 2^k when shamt[k] is set.
- Fill rules: SLL and SRL fill with 0. SRA fills with src[WIDTH-1]. ROL and ROR fill with the bits shifted out of the opposite end.
- Pass (op 000, 110, 111): out = src, cy = 0, shamt ignored.
- cy when shamt = 0: cy = 0 for every op.
- cy for SLL by n: src[WIDTH-n].
- cy for SRL/SRA by n: src[n-1].
- cy for ROL: out[0]. cy for ROR: out[WIDTH-1].
- zr = ~|out, computed from the final result and registered with it.
- REG_MID = 1 pipeline:
  - Stage A registers the partial result after levels 0..SHW/2-1, plus op, the remaining shamt bits, the cy candidate, tag and valid.
  - Stage B registers the final out, zr, cy, tag and out_valid.
  - Latency 2 cycles from acceptance to out_valid.
- REG_MID = 0: single stage B register; latency 1.
- Flow control:
  - A stage advances when it is empty or its downstream register advances this cycle.
  - stage B advances when ~out_valid | out_ready.
  - in_ready = advance condition of the first stage; it is combinational from out_ready but never from in_valid.
  - Full throughput: one beat per cycle when out_ready is held high.
- Backpressure: while out_valid & ~out_ready, out, zr, cy and tag_out hold stable. Upstream stages fill, then in_ready drops. No beat is dropped or duplicated, and order is preserved.
- Simultaneous events: when a stage is full and its output drains in the same cycle, it loads the new beat in that cycle (no bubble).
- Reset (async assert, sync deassert handled upstream):
  - All valid bits clear: out_valid = 0, in_ready = 1 after reset.
  - out = 0, zr = 0, cy = 0, tag_out = 0.
  - Beats in flight when rst_n falls are discarded.
- Data registers load only on advance, which limits toggling.
- No combinational path from src, shamt or op to any output.

Test Plan:
- WIDTH 16, REG_MID 1, out_ready = 1; SRA src 0x8001 shamt 4 -> two cycles later out 0xF800, cy 0, zr 0, tag echoed.
- SLL 0x8001 shamt 1 -> out 0x0002, cy 1. SRL 0x8001 shamt 1 -> out 0x4000, cy 1. SRL 0x0001 shamt 1 -> out 0x0000, zr 1, cy 1.
- ROR 0x0001 shamt 1 -> out 0x8000, cy 1. ROL 0x8000 shamt 3 -> out 0x0004, cy 0. Pass op 110 with shamt 7 -> out = src, cy 0.
- Back-to-back beats with tags 1..8 and out_ready = 1 -> eight consecutive out_valid cycles, in order, no bubbles. Repeat with REG_MID 0 -> latency 1.
- Hold out_ready = 0 while feeding three beats -> in_ready drops after two beats are held (REG_MID 1) and out stays stable. Release out_ready -> beats emerge in order, none lost.
- Assert rst_n = 0 mid-stream with two beats in flight -> out_valid = 0 and outputs 0 immediately. After release, no stale beat emerges and in_ready = 1.
